dac_sample_feeder: RTL and testbench
====================================

// Module: dac_sample_feeder
// PURPOSE
//  Upstream stage of DAC_Driver. Accepts paired ECG samples (14-bit two's complement, ch A/B) from the ADC path.
//  Converts them to 12-bit offset-binary DAC codes and buffers them in a small FIFO.
//  Presents one pair on Va/Vb per DAC refresh frame, paced by DAC_Driver's dacNumber.
//  Drives DAC_Driver startEnable once the FIFO is primed. All logic runs in the CLK_50M domain.
// PARAMETERS
//  DEPTH        4     FIFO depth in sample pairs; power of 2, >=2
//  PRIME_LEVEL  2     FIFO level required before startEnable asserts; 1..DEPTH
//  SHIFT        2     arithmetic right shift applied to 14-bit input before offset
//  OFFSET_CODE  2048  added after shift; maps signed 0 to mid-scale (1.65 V)
// PORTS
//  CLK_50M      in   1   system clock, 50 MHz
//  RST_N        in   1   asynchronous active-low reset
//  adc_a        in   14  ch A sample, two's complement
//  adc_b        in   14  ch B sample, two's complement
//  adc_valid    in   1   1-cycle strobe; adc_a/adc_b valid this cycle
//  dacNumber    in   1   from DAC_Driver (SPI_SCK domain); 0=ch A, 1=ch B being shifted
//  clear_flags  in   1   synchronous clear of overflow/underflow
//  Va           out  12  DAC ch A code to DAC_Driver
//  Vb           out  12  DAC ch B code to DAC_Driver
//  startEnable  out  1   to DAC_Driver; high while in RUN
//  fifo_level   out  $clog2(DEPTH)+1  pairs currently stored
//  overflow     out  1   sticky: a sample pair was dropped
//  underflow    out  1   sticky: a frame ended with FIFO empty
// BEHAVIOUR
//  Reset (RST_N=0, async):
//   - Va=Vb=OFFSET_CODE[11:0]; startEnable=0; fifo_level=0; overflow=underflow=0; state=PRIME.
//   - FIFO pointers zeroed; sync flops zeroed.
//  Conversion, applied at FIFO write:
//   - t = (sign-extended adc >>> SHIFT) + OFFSET_CODE, computed in 16-bit signed.
//   - Saturate: t<0 -> 0; t>4095 -> 4095. Store t[11:0].
//  Frame-done:
//   - dacNumber passes through a 2-flop synchroniser, then a third flop for edge detect.
//   - frame_done = 1-cycle pulse on synced falling edge (1->0): ch B finished, ch A starts.
//  Write:
//   - adc_valid=1 and level<DEPTH -> push; level+1.
//   - adc_valid=1 and level==DEPTH, no pop this cycle -> drop pair; overflow<=1.
//   - Full with simultaneous pop -> push accepted; level unchanged.
//  FSM:
//   - PRIME: startEnable=0; frame_done ignored.
//     When level>=PRIME_LEVEL: pop head into Va/Vb next edge; go RUN.
//   - RUN: startEnable=1 (registered; rises the same edge Va/Vb load).
//     On frame_done with level>0: pop; Va/Vb update on next edge (1-cycle latency).
//     On frame_done with level==0: Va/Vb hold last value; underflow<=1; stay RUN.
//   - RUN never returns to PRIME except via reset.
//  Simultaneous push+pop: both occur; level unchanged; pointers wrap mod DEPTH.
//  clear_flags: clears sticky flags next edge. A set event in the same cycle wins (flag stays 1).
//  Reset mid-frame: outputs return to reset values immediately. FIFO contents discarded.
// TESTING
//  1. Reset, then 2 pairs: A=0,B=0 and A=-8192,B=8191, with frame_done idle.
//     -> Va=2048,Vb=2048 loaded; startEnable=1. Second pair later: 0, 4095 (>>2 then +2048 = 0 / 4095).
//  2. OFFSET_CODE=4000, A=8191 -> 4000+2047 saturates to Va=4095.
//     OFFSET_CODE=0, A=-4 -> Va=0 (saturate low).
//  3. Toggle dacNumber 0->1->0 every 66 SPI_SCK periods, 1 pair per frame.
//     -> exactly 1 pop per falling edge; Va/Vb change 4 CLK_50M cycles after the edge reaches the input.
//  4. 5 adc_valid strobes with no frames (DEPTH=4, PRIME_LEVEL=4).
//     -> first 4 written, 1 popped on prime (level=3). 5th accepted; level=4, overflow=0.
//     6th -> dropped, overflow=1.
//  5. RUN with FIFO empty, one frame_done -> Va/Vb unchanged, underflow=1.
//     Then clear_flags -> underflow=0.
//  6. Push and frame_done in the same cycle at level=DEPTH -> level stays DEPTH, overflow=0, head pair output.
//     Assert RST_N=0 mid-run -> Va=Vb=2048, startEnable=0 asynchronously.

Source files
------------

// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: converts paired 14-bit ADC samples to 12-bit offset-binary DAC codes, buffers them, feeds one pair per DAC frame
// Ports:
//   CLK_50M, RST_N        clock, async active-low reset
//   adc_a, adc_b          14-bit two's complement samples, qualified by adc_valid strobe
//   dacNumber             DAC_Driver channel indicator (foreign domain); 1->0 marks frame end
//   clear_flags           sync clear of sticky overflow/underflow
//   Va, Vb                current DAC codes
//   startEnable           high once primed (RUN)
//   fifo_level            stored pairs
//   overflow, underflow   sticky drop / starve flags
module dac_sample_feeder #(
    parameter int DEPTH = 4,
    parameter int PRIME_LEVEL = 2,
    parameter int SHIFT = 2,
    parameter int OFFSET_CODE = 2048
) (
    input  logic                     CLK_50M,
    input  logic                     RST_N,
    input  logic [13:0]              adc_a,
    input  logic [13:0]              adc_b,
    input  logic                     adc_valid,
    input  logic                     dacNumber,
    input  logic                     clear_flags,
    output logic [11:0]              Va,
    output logic [11:0]              Vb,
    output logic                     startEnable,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PL = (AW+1)'(PRIME_LEVEL);
    localparam logic signed [15:0] OFF = 16'(OFFSET_CODE);
    localparam logic [0:0] PRIME = 1'b0, RUN = 1'b1;
    localparam logic [11:0] MID = 12'(OFFSET_CODE);

    function automatic logic [11:0] to_code(input logic [13:0] s);
        logic signed [15:0] t;
        t = ($signed({{2{s[13]}}, s}) >>> SHIFT) + OFF;
        return t < 16'sd0 ? 12'd0 : t > 16'sd4095 ? 12'hfff : t[11:0];
    endfunction

    logic [23:0]    mem [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [2:0]     sync;
    logic           frame_done;
    logic [0:0]     state;
    logic           push, pop;

    always_comb begin
        pop  = state == PRIME ? fifo_level >= PL : frame_done && fifo_level != '0;
        push = adc_valid && (fifo_level != FULL || pop);
    end

    assign startEnable = state == RUN;

    always_ff @(posedge CLK_50M)
        if (push) mem[wp] <= {to_code(adc_a), to_code(adc_b)};

    // sync[1:0] synchronise dacNumber, sync[2] is the edge-detect history;
    // frame_done is registered so it is a clean single-cycle pulse
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            sync       <= '0;
            frame_done <= 1'b0;
            wp         <= '0;
            rp         <= '0;
            fifo_level <= '0;
            Va         <= MID;
            Vb         <= MID;
            state      <= PRIME;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            sync       <= {sync[1:0], dacNumber};
            frame_done <= sync[2] & ~sync[1];
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp       <= rp + 1'b1;
                {Va, Vb} <= mem[rp];
            end
            fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
            state      <= pop ? RUN : state;
            overflow   <= (adc_valid && !push) || (overflow && !clear_flags);
            underflow  <= (state == RUN && frame_done && fifo_level == '0) || (underflow && !clear_flags);
        end
    end
endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb_dac_sample_feeder: directed self-checking bench for dac_sample_feeder
module tb_dac_sample_feeder;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [13:0] adc_a = '0, adc_b = '0;
    logic        adc_valid = 1'b0, dac_number = 1'b0, clear_flags = 1'b0;
    int          checks = 0, failures = 0;

    logic [11:0] va0, vb0, va_hi, vb_hi, va_lo, vb_lo, va_ov, vb_ov;
    logic        se0, se_hi, se_lo, se_ov, ov0, ov_hi, ov_lo, ov_ov, uf0, uf_hi, uf_lo, uf_ov;
    logic [2:0]  lv0, lv_hi, lv_lo, lv_ov;

    always #5 clk = ~clk;

    dac_sample_feeder u0 (.CLK_50M(clk), .RST_N(rst_n), .adc_a(adc_a), .adc_b(adc_b), .adc_valid(adc_valid),
        .dacNumber(dac_number), .clear_flags(clear_flags), .Va(va0), .Vb(vb0), .startEnable(se0),
        .fifo_level(lv0), .overflow(ov0), .underflow(uf0));
    dac_sample_feeder #(.PRIME_LEVEL(1), .OFFSET_CODE(4000)) u_hi (.CLK_50M(clk), .RST_N(rst_n), .adc_a(adc_a),
        .adc_b(adc_b), .adc_valid(adc_valid), .dacNumber(dac_number), .clear_flags(clear_flags), .Va(va_hi),
        .Vb(vb_hi), .startEnable(se_hi), .fifo_level(lv_hi), .overflow(ov_hi), .underflow(uf_hi));
    dac_sample_feeder #(.PRIME_LEVEL(1), .OFFSET_CODE(0)) u_lo (.CLK_50M(clk), .RST_N(rst_n), .adc_a(adc_a),
        .adc_b(adc_b), .adc_valid(adc_valid), .dacNumber(dac_number), .clear_flags(clear_flags), .Va(va_lo),
        .Vb(vb_lo), .startEnable(se_lo), .fifo_level(lv_lo), .overflow(ov_lo), .underflow(uf_lo));
    dac_sample_feeder #(.PRIME_LEVEL(4)) u_ov (.CLK_50M(clk), .RST_N(rst_n), .adc_a(adc_a), .adc_b(adc_b),
        .adc_valid(adc_valid), .dacNumber(dac_number), .clear_flags(clear_flags), .Va(va_ov), .Vb(vb_ov),
        .startEnable(se_ov), .fifo_level(lv_ov), .overflow(ov_ov), .underflow(uf_ov));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // called at a negedge; strobe lasts exactly one posedge
    task automatic push(input int a, input int b);
        adc_a = 14'(a);
        adc_b = 14'(b);
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    // full 0->1->0 frame; returns at the negedge after the 3rd posedge following the fall,
    // when the registered frame_done pulse is high
    task automatic frame_fall();
        dac_number = 1'b1;
        tick(6);
        dac_number = 1'b0;
        tick(3);
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        tick(2);
        chk("rst_va", va0, 2048);
        chk("rst_vb", vb0, 2048);
        chk("rst_se", se0, 0);
        chk("rst_lvl", lv0, 0);
        chk("rst_ovf", ov0, 0);
        chk("rst_udf", uf0, 0);
        rst_n = 1'b1;

        // saturation on alternate offsets, and overflow with PRIME_LEVEL=DEPTH
        push(8191, -4);
        tick();
        chk("sat_hi_va", va_hi, 4095);
        chk("hi_vb", vb_hi, 3999);
        chk("sat_lo_va", va_lo, 2047);
        chk("sat_lo_vb", vb_lo, 0);
        push(1, 1);
        push(2, 2);
        push(3, 3);
        chk("ov_lvl4", lv_ov, 4);
        chk("ov_se_prime", se_ov, 0);
        tick();
        chk("ov_lvl3", lv_ov, 3);
        chk("ov_se_run", se_ov, 1);
        chk("ov_va", va_ov, 4095);
        chk("ov_vb", vb_ov, 2047);
        push(4, 4);
        chk("ov_5th_lvl", lv_ov, 4);
        chk("ov_5th_flag", ov_ov, 0);
        push(5, 5);
        chk("ov_6th_lvl", lv_ov, 4);
        chk("ov_6th_flag", ov_ov, 1);

        reset_all();
        // priming with two pairs
        push(0, 0);
        chk("t1_lvl1", lv0, 1);
        push(-8192, 8191);
        chk("t1_lvl2", lv0, 2);
        chk("t1_se_prime", se0, 0);
        tick();
        chk("t1_va", va0, 2048);
        chk("t1_vb", vb0, 2048);
        chk("t1_se", se0, 1);
        chk("t1_lvl_after", lv0, 1);
        frame_fall();
        chk("t3_va_hold", va0, 2048);
        chk("t3_lvl_hold", lv0, 1);
        tick();
        chk("t1_va2", va0, 0);
        chk("t1_vb2", vb0, 4095);
        chk("t1_lvl0", lv0, 0);

        // underflow and clear
        frame_fall();
        tick();
        chk("t5_va", va0, 0);
        chk("t5_vb", vb0, 4095);
        chk("t5_udf", uf0, 1);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("t5_clr", uf0, 0);

        // one pop per frame
        push(100, -100);
        push(400, -400);
        chk("t3_lvl2", lv0, 2);
        frame_fall();
        tick();
        chk("t3_va1", va0, 2073);
        chk("t3_vb1", vb0, 2023);
        chk("t3_lvl1", lv0, 1);
        frame_fall();
        tick();
        chk("t3_va2", va0, 2148);
        chk("t3_vb2", vb0, 1948);
        chk("t3_lvl0", lv0, 0);
        chk("t3_udf", uf0, 0);

        // push and pop together at full
        push(-4, 4);
        push(8, -8);
        push(12, -12);
        push(16, -16);
        chk("t6_full", lv0, 4);
        frame_fall();
        push(20, -20);
        chk("t6_lvl", lv0, 4);
        chk("t6_ovf", ov0, 0);
        chk("t6_va", va0, 2047);
        chk("t6_vb", vb0, 2049);

        // asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_va", va0, 2048);
        chk("t6_arst_vb", vb0, 2048);
        chk("t6_arst_se", se0, 0);
        chk("t6_arst_lvl", lv0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
